demux_4_32: RTL and testbench
=============================

DEMUX_4_32 -- requirements
Module: demux_4_32

Interface
REQ-001 Parameter: WIDTH, 32, data width of the input word and of every output channel.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on the clk rising edge only.
REQ-004 in_valid  input  1  producer has a word on in_data and in_sel.
REQ-005 in_ready  output  1  block accepts the word this cycle.
REQ-006 in_sel  input  2  destination channel index, 0..3.
REQ-007 in_data  input  WIDTH  word to deliver.
REQ-008 out_valid  output  4  bit i: channel i holds an undelivered word.
REQ-009 out_ready  input  4  bit i: consumer i takes its word this cycle.
REQ-010 out_data0, out_data1, out_data2, out_data3  output  WIDTH each  per-channel held word.
REQ-011 pending  output  3  number of channels with out_valid set, 0..4.

Function
REQ-012 Each channel i SHALL own one holding slot: data register (drives out_data_i) and valid flag (drives out_valid[i]).
REQ-013 in_ready SHALL be combinational: !out_valid[in_sel] || out_ready[in_sel]; independent of in_valid.
REQ-014 Accept = in_valid && in_ready; on accept, slot in_sel loads in_data and sets its valid flag at the next edge; latency accept-to-out_valid is exactly 1 cycle.
REQ-015 Drain of channel i = out_valid[i] && out_ready[i]; on drain without a same-cycle load of i, valid flag i clears at the next edge.
REQ-016 Same-cycle drain and load of the same channel SHALL leave valid set with the new word; no bubble, no loss.
REQ-017 At most one channel loads per cycle; any subset of channels may drain in the same cycle as a load to another channel.
REQ-018 While out_valid[i]=1 and out_ready[i]=0, out_data_i SHALL stay stable.
REQ-019 out_data_i SHALL retain its last word after drain; only a load or reset changes it.
REQ-020 in_sel and in_data are ignored in cycles without accept; no state changes when in_valid=0.
REQ-021 Per-channel order SHALL be preserved; a word is never duplicated, dropped or routed to a channel other than in_sel.
REQ-022 pending SHALL be registered and equal the popcount of out_valid each cycle (+1 per load into an empty or draining-and-reloading-excluded slot, -1 per drain not replaced); never exceeds 4 or underflows.
REQ-023 out_ready[i] asserted while out_valid[i]=0 SHALL have no effect.

Reset
REQ-024 When reset=0 at a clk edge: all valid flags 0, all out_data_i 0, pending 0, regardless of in-flight handshakes; a word presented that cycle is discarded.
REQ-025 During reset (reset=0) in_ready MAY follow REQ-013, but no accept takes effect; first accept possible in the cycle after reset returns to 1.

Verification
REQ-026 After reset, in_valid=1, in_sel=2, in_data=32'hDEADBEEF, out_ready=0 -> next cycle out_valid=4'b0100, out_data2=DEADBEEF, pending=1; in_ready with in_sel=2 now 0.
REQ-027 Channel 1 full, out_ready=0, in_sel=1 data 32'h11 -> in_ready=0, out_data1 unchanged for 5 cycles; switch in_sel=3 data 32'h33 -> accepted, pending=2.
REQ-028 Channel 0 full with 32'hA, out_ready[0]=1, in_sel=0 data 32'hB same cycle -> next cycle out_valid[0]=1, out_data0=32'hB, pending unchanged.
REQ-029 All four channels full (pending=4), drain channels 0 and 3 simultaneously while loading channel 1 (also draining) -> pending=2, out_valid=4'b0110.
REQ-030 Reset asserted in the cycle of an accept to channel 2 with two channels full -> next cycle out_valid=0, pending=0, all out_data 0.
REQ-031 Random stimulus 10k cycles with scoreboard per channel -> zero order, loss, duplication or misroute errors; pending always equals popcount(out_valid).

Source files
------------

// File: rtl/demux_4_32.sv
// Routes one input word per cycle to one of four single-entry output slots; accept-to-out_valid is 1 cycle.
// in_ready drops only when the selected slot is full and its consumer is not draining it this cycle.
module demux_4_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [2:0]       pending
);

    logic [WIDTH-1:0] slot [4];
    logic             accept;
    logic [3:0]       load;
    logic [3:0]       drain;
    logic [3:0]       valid_nxt;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    // A full slot can still take a word when its consumer empties it on the same edge.
    assign in_ready = !out_valid[in_sel] || out_ready[in_sel];
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid & out_ready;

    always_comb begin
        load = '0;
        if (accept) begin
            load[in_sel] = 1'b1;
        end
    end

    assign valid_nxt = (out_valid & ~drain) | load;

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= '0;
            pending   <= '0;
            for (int i = 0; i < 4; i++) begin
                slot[i] <= '0;
            end
        end else begin
            out_valid <= valid_nxt;
            pending   <= popcount4(valid_nxt);
            if (accept) begin
                slot[in_sel] <= in_data;
            end
        end
    end

    assign out_data0 = slot[0];
    assign out_data1 = slot[1];
    assign out_data2 = slot[2];
    assign out_data3 = slot[3];

endmodule

// File: tb/tb_demux_4_32.sv
// Directed vector table plus random scoreboard run for demux_4_32.
module tb_demux_4_32;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_sel;
    logic [31:0] in_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data0, out_data1, out_data2, out_data3;
    logic [2:0]  pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux_4_32 #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3),
        .pending(pending)
    );

    typedef struct {
        logic        rst;
        logic        vld;
        logic [1:0]  sel;
        logic [31:0] dat;
        logic [3:0]  ordy;
        logic        exp_rdy;
        logic [3:0]  exp_ov;
        logic [2:0]  exp_pend;
        logic [1:0]  chk_ch;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic vld, input logic [1:0] sel,
                       input logic [31:0] dat, input logic [3:0] ordy, input logic exp_rdy,
                       input logic [3:0] exp_ov, input logic [2:0] exp_pend,
                       input logic [1:0] chk_ch, input logic [31:0] exp_dat);
        vec_t v;
        v.rst = rst; v.vld = vld; v.sel = sel; v.dat = dat; v.ordy = ordy;
        v.exp_rdy = exp_rdy; v.exp_ov = exp_ov; v.exp_pend = exp_pend;
        v.chk_ch = chk_ch; v.exp_dat = exp_dat;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dat_of(input logic [1:0] ch);
        case (ch)
            2'd0:    return out_data0;
            2'd1:    return out_data1;
            2'd2:    return out_data2;
            default: return out_data3;
        endcase
    endfunction

    logic [31:0] q [4][$];
    logic [3:0]  mv;
    int          mcnt;
    logic        d_rdy;
    logic [3:0]  drn;

    initial begin
        // rst vld sel data ordy | rdy(before edge) ov pend ch data(after edge)
        add(1, 1, 2, 32'hDEADBEEF, 4'b0000, 1, 4'b0100, 3'd1, 2, 32'hDEADBEEF);
        add(1, 0, 2, 32'h0,        4'b0000, 0, 4'b0100, 3'd1, 2, 32'hDEADBEEF);
        add(1, 0, 0, 32'h0,        4'b0100, 1, 4'b0000, 3'd0, 2, 32'hDEADBEEF);
        add(1, 1, 1, 32'h00001111, 4'b0000, 1, 4'b0010, 3'd1, 1, 32'h00001111);
        for (int k = 0; k < 5; k++)
            add(1, 1, 1, 32'h11,   4'b0000, 0, 4'b0010, 3'd1, 1, 32'h00001111);
        add(1, 1, 3, 32'h33,       4'b0000, 1, 4'b1010, 3'd2, 3, 32'h33);
        add(1, 0, 0, 32'h77,       4'b0101, 1, 4'b1010, 3'd2, 0, 32'h0);
        add(1, 1, 0, 32'hA,        4'b0000, 1, 4'b1011, 3'd3, 0, 32'hA);
        add(1, 1, 0, 32'hB,        4'b0001, 1, 4'b1011, 3'd3, 0, 32'hB);
        add(1, 1, 2, 32'hC,        4'b0000, 1, 4'b1111, 3'd4, 2, 32'hC);
        add(1, 1, 1, 32'h99,       4'b0000, 0, 4'b1111, 3'd4, 1, 32'h00001111);
        add(1, 1, 1, 32'hD1,       4'b1011, 1, 4'b0110, 3'd2, 1, 32'hD1);
        add(1, 0, 0, 32'h0,        4'b0000, 1, 4'b0110, 3'd2, 3, 32'h33);
        add(0, 1, 2, 32'hE2,       4'b0100, 1, 4'b0000, 3'd0, 2, 32'h0);
        add(1, 1, 0, 32'h5,        4'b0000, 1, 4'b0001, 3'd1, 0, 32'h5);

        // Reset with a word presented: it must be discarded.
        reset = 1'b0; in_valid = 1'b1; in_sel = 2'd1; in_data = 32'hFFFF_FFFF; out_ready = 4'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_pending",   32'(pending),   32'h0);
        chk("rst_data0", out_data0, 32'h0);
        chk("rst_data1", out_data1, 32'h0);
        chk("rst_data2", out_data2, 32'h0);
        chk("rst_data3", out_data3, 32'h0);

        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0;

        foreach (vecs[n]) begin
            @(negedge clk);
            reset = vecs[n].rst; in_valid = vecs[n].vld; in_sel = vecs[n].sel;
            in_data = vecs[n].dat; out_ready = vecs[n].ordy;
            #1;
            chk($sformatf("v%0d_in_ready", n), 32'(in_ready), 32'(vecs[n].exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", n), 32'(out_valid), 32'(vecs[n].exp_ov));
            chk($sformatf("v%0d_pending", n),   32'(pending),   32'(vecs[n].exp_pend));
            chk($sformatf("v%0d_data%0d", n, vecs[n].chk_ch), dat_of(vecs[n].chk_ch), vecs[n].exp_dat);
        end

        // After the reset vector every other slot must also read zero.
        chk("post_rst_data1", out_data1, 32'h0);
        chk("post_rst_data3", out_data3, 32'h0);

        // Random run against per-channel queues, starting from a fresh reset.
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; out_ready = 4'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) q[c].delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sel    = 2'($urandom_range(0, 3));
            in_data   = $urandom;
            out_ready = 4'($urandom_range(0, 15));
            #1;
            mcnt = 0;
            for (int c = 0; c < 4; c++) begin
                mv[c] = (q[c].size() != 0);
                if (mv[c]) mcnt++;
            end
            chk("rnd_out_valid", 32'(out_valid), 32'(mv));
            chk("rnd_pending",   32'(pending),   32'(mcnt));
            d_rdy = !mv[in_sel] || out_ready[in_sel];
            chk("rnd_in_ready",  32'(in_ready),  32'(d_rdy));
            drn = mv & out_ready;
            for (int c = 0; c < 4; c++) begin
                if (mv[c]) chk($sformatf("rnd_data%0d", c), dat_of(2'(c)), q[c][0]);
                if (drn[c]) void'(q[c].pop_front());
            end
            if (in_valid && d_rdy) q[in_sel].push_back(in_data);
            for (int c = 0; c < 4; c++) begin
                if (q[c].size() > 1) begin
                    errors++;
                    $display("FAIL rnd_depth ch%0d: got %0d entries expected at most 1", c, q[c].size());
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
